multicycle_controller: RTL and testbench

Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It handles handshakes with instruction fetch and data memory, and drives ALU command, register-file write enable and PC control. It also adds load/store, unconditional jump, BNEZ, HALT and illegal-opcode trapping. It sits between the instruction register/fetch unit and the datapath (ALU, register file, PC mux).

---
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: walks each opcode through FETCH/DECODE/EXEC/MEM/WB
// and drives fetch, data-memory, ALU, register-file and PC control for the datapath.
module multicycle_controller #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 4,
    parameter int ALU_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              fetch_ack,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic              mem_ready,
    output logic              fetch_req,
    output logic              ir_load,
    output logic [ALU_W-1:0]  alu_com,
    output logic              w_en,
    output logic              pc_en,
    output logic              pc_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(4'd0);
    localparam logic [OPC_W-1:0] OP_ONE   = OPC_W'(4'd1);
    localparam logic [OPC_W-1:0] OP_ALU_H = OPC_W'(4'd8);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(4'd9);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(4'd10);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(4'd11);
    localparam logic [OPC_W-1:0] OP_BEQZ  = OPC_W'(4'd12);
    localparam logic [OPC_W-1:0] OP_BNEZ  = OPC_W'(4'd13);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'd14);
    localparam logic [OPC_W-1:0] OP_ILL   = OPC_W'(4'd15);

    state_t             state_r;
    logic [OPC_W-1:0]   ir_r;
    logic               zflag_r;
    logic               illegal_r;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op >= OP_ONE) && (op <= OP_ALU_H);
    endfunction

    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Every code from 15 upward traps, which covers the extra codes of wider opcode fields.
    function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
        return op >= OP_ILL;
    endfunction

    // State sequencing, instruction register, branch zero flag and sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            ir_r      <= {OPC_W{1'b0}};
            zflag_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (fetch_ack) begin
                        ir_r    <= opcode;
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    zflag_r <= (reg1_data == {DATA_W{1'b0}});
                    if (ir_r == OP_NOP) begin
                        state_r <= S_FETCH;
                    end else if (ir_r == OP_HALT) begin
                        state_r <= S_HALT;
                    end else if (is_illegal_op(ir_r)) begin
                        illegal_r <= 1'b1;
                        state_r   <= S_HALT;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_alu_op(ir_r)) begin
                        state_r <= S_WB;
                    end else if (is_mem_op(ir_r)) begin
                        state_r <= S_MEM;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_r <= (ir_r == OP_LOAD) ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state_r <= S_FETCH;
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_FETCH;
            endcase
        end
    end

    // Output decode from state and IR; only the fetch and store-completion strobes look at the handshakes.
    always_comb begin
        fetch_req = 1'b0;
        ir_load   = 1'b0;
        alu_com   = {ALU_W{1'b0}};
        w_en      = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        halted    = 1'b0;
        case (state_r)
            S_FETCH: begin
                fetch_req = 1'b1;
                ir_load   = fetch_ack;
            end
            S_DECODE: begin
                pc_en = (ir_r == OP_NOP);
            end
            S_EXEC: begin
                alu_com = is_alu_op(ir_r) ? ALU_W'(ir_r - OP_ONE) : {ALU_W{1'b0}};
                pc_en   = (ir_r == OP_JMP) || (ir_r == OP_BEQZ) || (ir_r == OP_BNEZ);
                pc_sel  = (ir_r == OP_JMP) || ((ir_r == OP_BEQZ) && zflag_r)
                          || ((ir_r == OP_BNEZ) && !zflag_r);
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (ir_r == OP_STORE);
                pc_en   = (ir_r == OP_STORE) && mem_ready;
            end
            S_WB: begin
                alu_com = is_alu_op(ir_r) ? ALU_W'(ir_r - OP_ONE) : {ALU_W{1'b0}};
                w_en    = 1'b1;
                pc_en   = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                fetch_req = 1'b0;
            end
        endcase
    end

    assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: the driver pushes per-instruction
// expectations, a negedge monitor pops one at every PC update and compares what it observed.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        fetch_ack = 1'b0;
    logic [15:0] reg1_data = 16'd0;
    logic        mem_ready = 1'b0;
    logic        fetch_req, ir_load, w_en, pc_en, pc_sel, mem_req, mem_we, halted, illegal;
    logic [2:0]  alu_com;

    multicycle_controller #(.DATA_W(16), .OPC_W(4), .ALU_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fetch_ack(fetch_ack),
        .reg1_data(reg1_data), .mem_ready(mem_ready), .fetch_req(fetch_req),
        .ir_load(ir_load), .alu_com(alu_com), .w_en(w_en), .pc_en(pc_en),
        .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int pc_sel;
        int wen;
        int memc;
        int we;
        int alu;
        int cycles;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what one instruction must do, from the opcode rules and the wait counts.
    function automatic exp_t model(input int op, input int fd, input int md, input logic [15:0] r1);
        exp_t e;
        bit   z = (r1 == 16'd0);
        e.op = op; e.pc_sel = 0; e.wen = 0; e.memc = 0; e.we = 0; e.alu = 0;
        if (op == 0) begin
            e.cycles = fd + 2;
        end else if (op >= 1 && op <= 8) begin
            e.cycles = fd + 4; e.wen = 1; e.alu = op - 1;
        end else if (op == 9) begin
            e.cycles = fd + md + 5; e.wen = 1; e.memc = md + 1;
        end else if (op == 10) begin
            e.cycles = fd + md + 4; e.memc = md + 1; e.we = 1;
        end else begin
            e.cycles = fd + 3;
            e.pc_sel = (op == 11) ? 1 : (op == 12) ? int'(z) : int'(!z);
        end
        return e;
    endfunction

    // Monitor state accumulated between PC updates.
    int   cyc, nload, nwen, nmem, we_seen, alu_wb, alu_ex, alu_prev;
    exp_t e;

    // Observe the DUT each negedge and retire one scoreboard entry per PC update.
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            cyc = 0; nload = 0; nwen = 0; nmem = 0; we_seen = 0; alu_wb = 0; alu_ex = 0; alu_prev = 0;
        end else begin
            cyc++;
            if (ir_load) nload++;
            if (w_en) begin nwen++; alu_wb = alu_com; alu_ex = alu_prev; end
            if (mem_req) begin nmem++; we_seen = mem_we; end
            alu_prev = alu_com;
            chk("strobe_qual", int'((pc_sel || w_en) && !pc_en), 0);
            if (pc_en) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("op%0d_cycles", e.op), cyc, e.cycles);
                    chk($sformatf("op%0d_pc_sel", e.op), pc_sel, e.pc_sel);
                    chk($sformatf("op%0d_ir_load", e.op), nload, 1);
                    chk($sformatf("op%0d_w_en", e.op), nwen, e.wen);
                    chk($sformatf("op%0d_mem_cycles", e.op), nmem, e.memc);
                    if (e.memc > 0) chk($sformatf("op%0d_mem_we", e.op), we_seen, e.we);
                    if (e.wen > 0) begin
                        chk($sformatf("op%0d_alu_exec", e.op), alu_ex, e.alu);
                        chk($sformatf("op%0d_alu_wb", e.op), alu_wb, e.alu);
                    end
                end
                cyc = 0; nload = 0; nwen = 0; nmem = 0; we_seen = 0; alu_wb = 0; alu_ex = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction on a fixed schedule, with noise on handshakes the DUT must ignore.
    task automatic run_instr(input int op, input int fd, input int md, input logic [15:0] r1);
        for (int i = 0; i < fd; i++) begin
            fetch_ack = 1'b0; opcode = 4'($urandom); mem_ready = 1'($urandom); tick();
        end
        fetch_ack = 1'b1; opcode = 4'(op); mem_ready = 1'($urandom); tick();
        fetch_ack = 1'($urandom); opcode = 4'($urandom); reg1_data = r1; tick();
        if (op == 0 || op >= 14) return;
        reg1_data = (r1 == 16'd0) ? 16'd5 : 16'd0;
        fetch_ack = 1'($urandom); mem_ready = 1'($urandom); tick();
        if (op >= 11) return;
        if (op >= 9) begin
            for (int i = 0; i < md; i++) begin
                mem_ready = 1'b0; fetch_ack = 1'($urandom); tick();
            end
            mem_ready = 1'b1; tick();
            if (op == 10) return;
        end
        fetch_ack = 1'($urandom); mem_ready = 1'($urandom); tick();
    endtask

    task automatic do_reset;
        fetch_ack = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    endtask

    initial begin
        int op, fd, md, sel;
        logic [15:0] r1;
        tick(); tick();
        chk("rst_fetch_req", fetch_req, 1);
        chk("rst_strobes", int'({ir_load, w_en, pc_en, pc_sel, mem_req, mem_we, halted, illegal}), 0);
        chk("rst_alu_com", alu_com, 0);
        rst_n = 1'b1; #1;
        mon_en = 1'b1;

        for (int n = 0; n < 200; n++) begin
            op  = (n < 4) ? (n == 0 ? 3 : 12) : $urandom_range(0, 13);
            fd  = (n < 4) ? 0 : $urandom_range(0, 2);
            md  = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            r1  = (n == 1) ? 16'd0 : (n == 2) ? 16'h8000 :
                  (sel == 0) ? 16'd0 : (sel == 1) ? 16'h8000 : 16'($urandom);
            sb.push_back(model(op, fd, md, r1));
            run_instr(op, fd, md, r1);
        end
        fetch_ack = 1'b0; tick(); tick();
        chk("sb_drained", sb.size(), 0);
        mon_en = 1'b0;

        run_instr(14, 1, 0, 16'd0);
        chk("halt_halted", halted, 1);
        chk("halt_illegal", illegal, 0);
        for (int i = 0; i < 5; i++) begin
            fetch_ack = 1'b1; mem_ready = 1'b1; tick();
            chk("halt_quiet", int'({fetch_req, ir_load, pc_en, w_en, mem_req}), 0);
        end
        do_reset();

        run_instr(15, 0, 0, 16'd0);
        chk("ill_illegal", illegal, 1);
        chk("ill_halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            fetch_ack = 1'($urandom); mem_ready = 1'($urandom); tick();
            chk("ill_hold", int'({fetch_req, illegal}), 1);
        end
        fetch_ack = 1'b0; rst_n = 1'b0; #2;
        chk("ill_cleared", illegal, 0);
        chk("ill_rst_fetch_req", fetch_req, 1);
        tick(); rst_n = 1'b1; #1;

        fetch_ack = 1'b1; opcode = 4'd9; tick();
        fetch_ack = 1'b0; tick(); tick();
        mem_ready = 1'b0; tick();
        chk("mem_req_held", int'({mem_req, mem_we}), 2);
        #2 rst_n = 1'b0; #1;
        chk("midmem_rst", int'({mem_req, w_en, pc_en, ir_load, halted}), 0);
        @(posedge clk); #1 rst_n = 1'b1; #1;
        chk("midmem_fetch_req", fetch_req, 1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; tick();
            chk("midmem_no_wen", int'({w_en, mem_req}), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
